// File: rtl/flb_band_cal_ctrl.sv
// Coarse-band calibration sequencer for the DCO/FLB analog top.
// MSB-first successive-approximation search of the DCO band word, one
// measurement per bit, followed by FLB reset release and delayed SDM enable.
// Everything runs on ref_clk; fb_cnt/fb_cnt_vld arrive already synchronised.
module flb_band_cal_ctrl #(
   parameter int BAND_W      = 8,
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int SDM_DLY     = 8
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic              cal_start,
   input  logic [CNT_W-1:0]  cal_target,
   input  logic              sdm_req,
   input  logic [CNT_W-1:0]  fb_cnt,
   input  logic              fb_cnt_vld,
   output logic [BAND_W-1:0] band,
   output logic              meas_start,
   output logic              flb_rst_n,
   output logic              sdm_on,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err
);

   // One shared down-counter serves settle, timeout and SDM delay.
   localparam int MAX_A = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int MAX_C = (MAX_A > SDM_DLY) ? MAX_A : SDM_DLY;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam int IW    = (BAND_W > 1) ? $clog2(BAND_W) : 1;

   localparam logic [CW-1:0]     SETTLE_LD  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]     TIMEOUT_LD = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0]     SDM_LD     = CW'(SDM_DLY - 1);
   localparam logic [IW-1:0]     IDX_TOP    = IW'(BAND_W - 1);
   localparam logic [BAND_W-1:0] BAND_ONE   = BAND_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_WAIT, S_DECIDE, S_RELEASE, S_SDM_WAIT, S_DONE, S_ERR
   } state_t;

   state_t            r_state,      w_state_nx;
   logic [CW-1:0]     r_cnt,        w_cnt_nx;
   logic [IW-1:0]     r_idx,        w_idx_nx;
   logic [BAND_W-1:0] r_result,     w_result_nx;
   logic [BAND_W-1:0] r_band,       w_band_nx;
   logic [CNT_W-1:0]  r_target,     w_target_nx;
   logic              r_sdm_req,    w_sdm_req_nx;
   logic              r_lt,         w_lt_nx;
   logic              r_meas_start, w_meas_start_nx;
   logic              r_flb_rst_n,  w_flb_rst_n_nx;
   logic              r_sdm_on,     w_sdm_on_nx;
   logic              r_busy,       w_busy_nx;
   logic              r_done,       w_done_nx;
   logic              r_err,        w_err_nx;
   logic [BAND_W-1:0] w_res_upd;

   assign band       = r_band;
   assign meas_start = r_meas_start;
   assign flb_rst_n  = r_flb_rst_n;
   assign sdm_on     = r_sdm_on;
   assign cal_busy   = r_busy;
   assign cal_done   = r_done;
   assign cal_err    = r_err;

   // State and all registered outputs; reset returns everything to idle values.
   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_result     <= '0;
         r_band       <= '0;
         r_target     <= '0;
         r_sdm_req    <= 1'b0;
         r_lt         <= 1'b0;
         r_meas_start <= 1'b0;
         r_flb_rst_n  <= 1'b0;
         r_sdm_on     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_idx        <= w_idx_nx;
         r_result     <= w_result_nx;
         r_band       <= w_band_nx;
         r_target     <= w_target_nx;
         r_sdm_req    <= w_sdm_req_nx;
         r_lt         <= w_lt_nx;
         r_meas_start <= w_meas_start_nx;
         r_flb_rst_n  <= w_flb_rst_n_nx;
         r_sdm_on     <= w_sdm_on_nx;
         r_busy       <= w_busy_nx;
         r_done       <= w_done_nx;
         r_err        <= w_err_nx;
      end
   end

   // Next-state and next-output logic; everything holds unless a state acts.
   always_comb begin
      w_state_nx      = r_state;
      w_cnt_nx        = r_cnt;
      w_idx_nx        = r_idx;
      w_result_nx     = r_result;
      w_band_nx       = r_band;
      w_target_nx     = r_target;
      w_sdm_req_nx    = r_sdm_req;
      w_lt_nx         = r_lt;
      w_meas_start_nx = 1'b0;
      w_flb_rst_n_nx  = r_flb_rst_n;
      w_sdm_on_nx     = r_sdm_on;
      w_busy_nx       = r_busy;
      w_done_nx       = r_done;
      w_err_nx        = r_err;
      // Result with the bit under trial resolved by the last comparison.
      w_res_upd        = r_result;
      w_res_upd[r_idx] = r_lt;

      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (cal_start) begin
               w_target_nx    = cal_target;
               w_sdm_req_nx   = sdm_req;
               w_result_nx    = '0;
               w_idx_nx       = IDX_TOP;
               w_band_nx      = BAND_ONE << IDX_TOP;
               w_flb_rst_n_nx = 1'b0;
               w_sdm_on_nx    = 1'b0;
               w_done_nx      = 1'b0;
               w_err_nx       = 1'b0;
               w_busy_nx      = 1'b1;
               w_cnt_nx       = SETTLE_LD;
               w_state_nx     = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == '0) begin
               w_meas_start_nx = 1'b1;
               w_cnt_nx        = TIMEOUT_LD;
               w_state_nx      = S_WAIT;
            end else begin
               w_cnt_nx = r_cnt - CW'(1);
            end
         end
         S_WAIT: begin
            // A strobe on the final timeout cycle still counts as a measurement.
            if (fb_cnt_vld) begin
               w_lt_nx    = (fb_cnt < r_target);
               w_state_nx = S_DECIDE;
            end else if (r_cnt == '0) begin
               w_busy_nx      = 1'b0;
               w_err_nx       = 1'b1;
               w_flb_rst_n_nx = 1'b0;
               w_sdm_on_nx    = 1'b0;
               w_state_nx     = S_ERR;
            end else begin
               w_cnt_nx = r_cnt - CW'(1);
            end
         end
         S_DECIDE: begin
            // Equal counts clear the bit: the band ends strictly below target.
            w_result_nx = w_res_upd;
            if (r_idx == '0) begin
               w_band_nx  = w_res_upd;
               w_state_nx = S_RELEASE;
            end else begin
               w_idx_nx   = r_idx - IW'(1);
               w_band_nx  = w_res_upd | (BAND_ONE << (r_idx - IW'(1)));
               w_cnt_nx   = SETTLE_LD;
               w_state_nx = S_SETTLE;
            end
         end
         S_RELEASE: begin
            w_flb_rst_n_nx = 1'b1;
            w_cnt_nx       = SDM_LD;
            w_state_nx     = S_SDM_WAIT;
         end
         S_SDM_WAIT: begin
            if (r_cnt == '0) begin
               w_sdm_on_nx = r_sdm_req;
               w_busy_nx   = 1'b0;
               w_done_nx   = 1'b1;
               w_state_nx  = S_DONE;
            end else begin
               w_cnt_nx = r_cnt - CW'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_flb_band_cal_ctrl.sv
// Bench for flb_band_cal_ctrl: a frequency-counter responder driven by a
// band->count model, a vector table, hand-written corner sequences and
// randomized linear-DCO runs checked against an exhaustive-search reference.
module tb_flb_band_cal_ctrl;

   localparam int SETTLE_CYC = 16;
   localparam int SDM_DLY    = 8;

   logic        ref_clk = 1'b0;
   logic        rst, cal_start, sdm_req, fb_cnt_vld;
   logic [15:0] cal_target, fb_cnt;
   logic [7:0]  band;
   logic        meas_start, flb_rst_n, sdm_on, cal_busy, cal_done, cal_err;

   flb_band_cal_ctrl #(
      .BAND_W(8), .CNT_W(16), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(1024), .SDM_DLY(SDM_DLY)
   ) dut (
      .ref_clk(ref_clk), .rst(rst), .cal_start(cal_start), .cal_target(cal_target),
      .sdm_req(sdm_req), .fb_cnt(fb_cnt), .fb_cnt_vld(fb_cnt_vld), .band(band),
      .meas_start(meas_start), .flb_rst_n(flb_rst_n), .sdm_on(sdm_on),
      .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
   );

   always #5 ref_clk = ~ref_clk;

   // Environment: 0 = linear (band*slope), 1 = always 0, 2 = always 0xFFFF, 3 = never answers
   int         mode, slope, dly;
   bit         spur;
   int         meas_cnt;
   logic [7:0] trial_q[$];
   int         n_cmp = 0, n_mis = 0;

   function automatic logic [15:0] fmodel(input int m, input int sl, input logic [7:0] c);
      case (m)
         0:       return 16'(int'(c) * sl);
         1:       return 16'h0000;
         default: return 16'hFFFF;
      endcase
   endfunction

   // Largest band whose count is strictly below target (0 if none).
   function automatic logic [7:0] ref_band(input int m, input int sl, input logic [15:0] tgt);
      logic [7:0] best;
      best = 8'h00;
      for (int c = 0; c < 256; c++)
         if (fmodel(m, sl, 8'(c)) < tgt) best = 8'(c);
      return best;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Counter responder: answers d cycles after meas_start (d=0 -> same cycle).
   initial begin
      bit pend;
      int cd;
      pend = 1'b0; cd = 0;
      fb_cnt_vld = 1'b0; fb_cnt = 16'h0;
      forever begin
         @(negedge ref_clk);
         fb_cnt_vld = 1'b0;
         if (rst) pend = 1'b0;
         if (meas_start && !rst) begin
            meas_cnt++;
            trial_q.push_back(band);
            if (mode != 3) begin pend = 1'b1; cd = dly; end
         end
         if (pend) begin
            if (cd == 0) begin
               fb_cnt = fmodel(mode, slope, band);
               fb_cnt_vld = 1'b1;
               pend = 1'b0;
            end else cd--;
         end else if (spur && !meas_start) begin
            fb_cnt = 16'h0000;   // would set every bit if it were accepted
            fb_cnt_vld = 1'b1;
         end
      end
   end

   // Called at a negedge; returns cycles from start acceptance to done/err.
   task automatic run_cal(input int m, input int sl, input logic [15:0] tgt, input logic sr,
                          input int d, input bit sp, input bit mid, input string tag,
                          output int cyc, output int flb_cyc);
      mode = m; slope = sl; dly = d; spur = sp; cal_target = tgt; sdm_req = sr;
      meas_cnt = 0; trial_q.delete();
      cal_start = 1'b1;
      @(negedge ref_clk);
      cal_start = 1'b0;
      check({tag, "_start_busy"}, 32'(cal_busy), 1);
      check({tag, "_start_err"}, 32'(cal_err), 0);
      check({tag, "_start_done"}, 32'(cal_done), 0);
      check({tag, "_start_band"}, 32'(band), 32'h80);
      cyc = 0; flb_cyc = -1;
      while (!(cal_done || cal_err) && cyc < 5000) begin
         @(negedge ref_clk);
         cyc++;
         cal_start = (mid && cyc == 50);
         if (flb_rst_n && flb_cyc < 0) flb_cyc = cyc;
      end
      cal_start = 1'b0;
      if (cyc >= 5000) check({tag, "_done_wait_timeout"}, 32'(cyc), 0);
   endtask

   task automatic check_end(input string tag, input logic [7:0] e_band, input int e_meas,
                            input logic e_err, input logic e_sdm, input int e_cyc,
                            input int cyc, input int flb_cyc);
      check({tag, "_band"}, 32'(band), 32'(e_band));
      check({tag, "_meas_cnt"}, 32'(meas_cnt), 32'(e_meas));
      check({tag, "_err"}, 32'(cal_err), 32'(e_err));
      check({tag, "_done"}, 32'(cal_done), 32'(!e_err));
      check({tag, "_busy"}, 32'(cal_busy), 0);
      check({tag, "_flb_rst_n"}, 32'(flb_rst_n), 32'(!e_err));
      check({tag, "_sdm_on"}, 32'(sdm_on), 32'(e_err ? 1'b0 : e_sdm));
      check({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
      check({tag, "_flb_rise"}, 32'(flb_cyc), e_err ? 32'hFFFF_FFFF : 32'(e_cyc - SDM_DLY));
   endtask

   typedef struct {
      int          mode;
      int          slope;
      logic [15:0] tgt;
      logic        sdm;
      int          dly;
      bit          spur;
      bit          mid;
      logic [7:0]  e_band;
      int          e_meas;
      logic        e_err;
      int          e_cyc;
   } vec_t;

   vec_t tbl[8];
   logic [7:0] seq_exp[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, flb_cyc, w;
      rst = 1'b1; cal_start = 1'b0; cal_target = 16'h0; sdm_req = 1'b0;
      mode = 0; slope = 32; dly = 0; spur = 1'b0; meas_cnt = 0;

      seq_exp = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h48, 8'h4C, 8'h4E, 8'h4F};
      // Trial = SETTLE + (d+1) + DECIDE; 8 trials, then RELEASE + SDM_DLY.
      tbl[0] = '{0, 32, 16'h0A00, 1'b1, 4, 1'b0, 1'b0, 8'h4F, 8, 1'b0, 185};
      tbl[1] = '{1, 32, 16'h0A00, 1'b1, 4, 1'b0, 1'b0, 8'hFF, 8, 1'b0, 185};
      tbl[2] = '{2, 32, 16'h0A00, 1'b1, 2, 1'b0, 1'b0, 8'h00, 8, 1'b0, 169};
      tbl[3] = '{0, 32, 16'h0800, 1'b1, 4, 1'b0, 1'b0, 8'h3F, 8, 1'b0, 185};
      tbl[4] = '{0, 32, 16'h0A00, 1'b0, 0, 1'b0, 1'b0, 8'h4F, 8, 1'b0, 153};
      tbl[5] = '{3, 32, 16'h0A00, 1'b1, 0, 1'b0, 1'b0, 8'h80, 1, 1'b1, 1040};
      tbl[6] = '{0, 32, 16'h0A00, 1'b1, 4, 1'b1, 1'b0, 8'h4F, 8, 1'b0, 185};
      tbl[7] = '{0, 32, 16'h0A00, 1'b1, 3, 1'b0, 1'b1, 8'h4F, 8, 1'b0, 177};

      repeat (3) @(negedge ref_clk);
      check("rst_band", 32'(band), 0);
      check("rst_meas_start", 32'(meas_start), 0);
      check("rst_flb_rst_n", 32'(flb_rst_n), 0);
      check("rst_sdm_on", 32'(sdm_on), 0);
      check("rst_busy", 32'(cal_busy), 0);
      check("rst_done", 32'(cal_done), 0);
      check("rst_err", 32'(cal_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge ref_clk);

      for (int i = 0; i < 8; i++) begin
         string tag;
         tag = $sformatf("row%0d", i);
         run_cal(tbl[i].mode, tbl[i].slope, tbl[i].tgt, tbl[i].sdm, tbl[i].dly,
                 tbl[i].spur, tbl[i].mid, tag, cyc, flb_cyc);
         check_end(tag, tbl[i].e_band, tbl[i].e_meas, tbl[i].e_err, tbl[i].sdm,
                   tbl[i].e_cyc, cyc, flb_cyc);
         if (i == 0)
            for (int k = 0; k < 8; k++)
               check($sformatf("row0_trial%0d", k), 32'(trial_q.size() > k ? trial_q[k] : 8'hXX),
                     32'(seq_exp[k]));
         repeat (3) @(negedge ref_clk);
         if (i == 4) check("row4_sdm_stays_off", 32'(sdm_on), 0);
      end

      // rst while waiting for a measurement, then a clean restart.
      mode = 0; slope = 32; dly = 4; spur = 1'b0; cal_target = 16'h0A00; sdm_req = 1'b1;
      cal_start = 1'b1;
      @(negedge ref_clk);
      cal_start = 1'b0;
      w = 0;
      while (!meas_start && w < 100) begin @(negedge ref_clk); w++; end
      check("rstw_meas_seen", 32'(meas_start), 1);
      @(negedge ref_clk);
      rst = 1'b1;
      @(negedge ref_clk);
      check("rstw_band", 32'(band), 0);
      check("rstw_meas_start", 32'(meas_start), 0);
      check("rstw_flb_rst_n", 32'(flb_rst_n), 0);
      check("rstw_sdm_on", 32'(sdm_on), 0);
      check("rstw_busy", 32'(cal_busy), 0);
      check("rstw_done", 32'(cal_done), 0);
      check("rstw_err", 32'(cal_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge ref_clk);
      run_cal(0, 32, 16'h0A00, 1'b1, 4, 1'b0, 1'b0, "after_rst", cyc, flb_cyc);
      check_end("after_rst", 8'h4F, 8, 1'b0, 1'b1, 185, cyc, flb_cyc);
      check("after_rst_trial0", 32'(trial_q.size() > 0 ? trial_q[0] : 8'hXX), 32'h80);

      // Randomized linear DCO against the exhaustive-search reference.
      for (int r = 0; r < 6; r++) begin
         int sl, d, ecyc;
         logic [15:0] tgt;
         logic sr;
         sl   = $urandom_range(1, 64);
         tgt  = 16'($urandom_range(0, 17000));
         d    = $urandom_range(0, 6);
         sr   = 1'($urandom_range(0, 1));
         ecyc = 8 * (SETTLE_CYC + (d + 1) + 1) + 1 + SDM_DLY;
         run_cal(0, sl, tgt, sr, d, 1'b0, 1'b0, $sformatf("rnd%0d", r), cyc, flb_cyc);
         check_end($sformatf("rnd%0d", r), ref_band(0, sl, tgt), 8, 1'b0, sr, ecyc, cyc, flb_cyc);
         repeat (2) @(negedge ref_clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
